// File: rtl/muldiv_if.sv
// Issue/result bundle between the decode stage and the HI/LO multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, x, y, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, x, y, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// one result bit per clock. Define MULDIV_SIGNED_EN to make ops 1/3 signed (else unsigned).
module muldiv_unit (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_b, r_hi, r_lo;
  logic        r_is_div, r_done, r_dz;

  logic        w_go, w_arith, w_dz_start;
  logic [31:0] w_xmag, w_ymag;
  logic [32:0] w_madd, w_rsh, w_rsub;
  logic [63:0] w_mres;
  logic [31:0] w_q, w_r;

  assign w_go       = bus.start && (r_state == IDLE);
  assign w_arith    = w_go && !bus.op[2];
  assign w_dz_start = w_arith && bus.op[1] && (bus.y == 32'd0);

`ifdef MULDIV_SIGNED_EN
  logic r_neg_q, r_neg_r;
  logic w_xneg, w_yneg;
  assign w_xneg = bus.op[0] && bus.x[31];
  assign w_yneg = bus.op[0] && bus.y[31];
  assign w_xmag = w_xneg ? (~bus.x + 32'd1) : bus.x;
  assign w_ymag = w_yneg ? (~bus.y + 32'd1) : bus.y;
  assign w_mres = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_q    = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_r    = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
`else
  assign w_xmag = bus.x;
  assign w_ymag = bus.y;
  assign w_mres = r_acc;
  assign w_q    = r_acc[31:0];
  assign w_r    = r_acc[63:32];
`endif

  // Multiply: acc = {partial product high, multiplier shifting out}; r_b holds multiplicand.
  // Divide:   acc = {remainder, quotient/dividend}; r_b holds divisor.
  assign w_madd = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_rsh  = {r_acc[63:32], r_acc[31]};
  assign w_rsub = w_rsh - {1'b0, r_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arith) w_next = w_dz_start ? FIN : RUN;
      RUN:     if (r_cnt == 6'd1) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_b      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == FIN);
      if (w_go && bus.op == 3'd4) r_hi <= bus.x;
      if (w_go && bus.op == 3'd5) r_lo <= bus.x;
      if (w_arith) begin
        r_dz <= w_dz_start;
        if (!w_dz_start) begin
          r_is_div <= bus.op[1];
          r_cnt    <= 6'd32;
          r_acc    <= {32'd0, (bus.op[1] ? w_xmag : w_ymag)};
          r_b      <= bus.op[1] ? w_ymag : w_xmag;
`ifdef MULDIV_SIGNED_EN
          r_neg_q  <= w_xneg ^ w_yneg;
          r_neg_r  <= w_xneg;
`endif
        end
      end
      if (r_state == RUN) begin
        r_cnt <= r_cnt - 6'd1;
        if (!r_is_div)
          r_acc <= {w_madd, r_acc[31:1]};
        else if (!w_rsub[32])
          r_acc <= {w_rsub[31:0], r_acc[30:0], 1'b1};
        else
          r_acc <= {w_rsh[31:0], r_acc[30:0], 1'b0};
      end
      // Divide-by-zero reaches FIN with hi/lo untouched.
      if (r_state == FIN && !r_dz) begin
        if (r_is_div) begin
          r_hi <= w_r;
          r_lo <= w_q;
        end else begin
          r_hi <= w_mres[63:32];
          r_lo <= w_mres[31:0];
        end
      end
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit using a scoreboard of expected HI/LO results.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  muldiv_if bus();

  muldiv_unit u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  function automatic exp_t model(logic [2:0] op, logic [31:0] x, logic [31:0] y,
                                 logic [31:0] ph, logic [31:0] pl);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sx, sy, q, r;
    bit sg;
`ifdef MULDIV_SIGNED_EN
    sg = op[0];
`else
    sg = 1'b0;
`endif
    e.dz = 1'b0; e.lat = 33;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (!op[1]) begin
      if (sg) p = sx * sy;
      else    p = {32'd0, x} * {32'd0, y};
      e.hi = p[63:32]; e.lo = p[31:0];
    end else if (y == 32'd0) begin
      e.dz = 1'b1; e.lat = 1; e.hi = ph; e.lo = pl;
    end else if (sg) begin
      q = sx / sy; r = sx % sy;
      e.lo = q[31:0]; e.hi = r[31:0];
    end else begin
      e.lo = x / y; e.hi = x % y;
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns at the negedge after the accepting edge.
  task automatic start_op(logic [2:0] op, logic [31:0] x, logic [31:0] y, bit now);
    if (!now) @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.x = x; bus.y = y;
    if (op < 3'd4) sb.push_back(model(op, x, y, m_hi, m_lo));
    @(negedge clk);
    bus.start = 1'b0; bus.x = 32'hDEAD_BEEF; bus.y = 32'hFEED_F00D;
    if (op < 3'd4) chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done(string tag, int k0);
    int k;
    exp_t e;
    k = k0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.done && k < 100);
    e = sb.pop_front();
    chk({tag, "_lat"},  k, e.lat);
    chk({tag, "_hi"},   bus.hi, e.hi);
    chk({tag, "_lo"},   bus.lo, e.lo);
    chk({tag, "_dz"},   {31'd0, bus.div_zero}, {31'd0, e.dz});
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic mt(logic [31:0] hv, logic [31:0] lv);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.x = hv;
    @(negedge clk);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    chk("mthi_hi", bus.hi, hv);
    bus.op = 3'd5; bus.x = lv;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    chk("mtlo_done", {31'd0, bus.done}, 32'd0);
    chk("mt_hi", bus.hi, hv);
    chk("mt_lo", bus.lo, lv);
    m_hi = hv; m_lo = lv;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] rx, ry;
    bus.start = 1'b0; bus.op = 3'd0; bus.x = 32'd0; bus.y = 32'd0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dz",   {31'd0, bus.div_zero}, 32'd0);
    chk("rst_hi",   bus.hi, 32'd0);
    chk("rst_lo",   bus.lo, 32'd0);
    @(negedge clk); rst = 1'b0;

    start_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0);         wait_done("multu", 0);
    start_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);         wait_done("mult", 0);
    start_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);         wait_done("div_neg7", 0);
    start_op(3'd2, 32'd100, 32'd7, 0);               wait_done("divu_100_7", 0);
    start_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_done("div_ovf", 0);

    mt(32'h0000_ABCD, 32'h0000_1234);
    mt(32'h0000_0011, 32'h0000_0022);
    start_op(3'd2, 32'd7, 32'd0, 0);                 wait_done("divu_zero", 0);
    start_op(3'd0, 32'd3, 32'd4, 0);                 wait_done("multu_clr_dz", 0);

    // Starts while busy must not disturb the running op nor HI/LO.
    start_op(3'd0, 32'h0001_2345, 32'h0000_0010, 0);
    repeat (5) @(negedge clk);
    chk("hold_hi_mid", bus.hi, m_hi);
    bus.start = 1'b1; bus.op = 3'd4; bus.x = 32'h0000_DEAD;
    @(negedge clk);
    bus.op = 3'd0; bus.x = 32'd9; bus.y = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold_lo_mid", bus.lo, m_lo);
    wait_done("busy_start", 7);

    // Back-to-back: each new op issued in the cycle done is high.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      rx  = $urandom;
      ry  = $urandom;
      if (i % 2 == 1) ry = ry >> $urandom_range(0, 31);
      if (i == 5) begin rop = 3'd3; ry = 32'd0; end
      start_op(rop, rx, ry, 1);
      wait_done($sformatf("rnd%0d", i), 0);
    end

    mt(32'h0000_0055, 32'h0000_0066);
    start_op(3'd0, 32'h1234_5678, 32'h09AB_CDEF, 0);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
    chk("rst_mid_hi",   bus.hi, 32'd0);
    chk("rst_mid_lo",   bus.lo, 32'd0);
    void'(sb.pop_back());
    @(negedge clk); rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    start_op(3'd0, 32'd3, 32'd5, 0);                 wait_done("multu_3x5", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO register pair of the MIPS datapath. The single-cycle ALU's combinational mul/div path is replaced by this block. The decode stage issues a one-cycle start, and the pipeline stalls while busy is high. mfhi/mflo read the registered hi/lo outputs directly. One result bit is produced per clock, using shift-add for multiply and restoring division for divide.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue op this cycle; sampled only when busy=0
- op  in  3  0 multu, 1 mult, 2 divu, 3 div, 4 mthi, 5 mtlo, 6–7 no-op
- x  in  32  multiplicand / dividend / mthi-mtlo source
- y  in  32  multiplier / divisor
- busy  out  1  operation in progress; pipeline must stall
- done  out  1  one-cycle pulse; hi/lo valid this cycle
- div_zero  out  1  last accepted divide had y=0
- hi  out  32  HI register (mul upper word / div remainder)
- lo  out  32  LO register (mul lower word / div quotient)

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start with op 0–3, y≠0 or op 0–1:
  - latch operand magnitudes and result-sign flags
  - clear div_zero
  - load 6-bit iteration counter with 32
  - go to RUN
- IDLE, start with op 2–3 and y=0:
  - set div_zero
  - go to FIN
  - hi/lo keep their previous values
- IDLE, start with op 4/5: hi (or lo) ← x at that edge; no busy, no done; stay in IDLE.
- IDLE, start with op 6/7: ignored.
- RUN, multiply: each edge, if the multiplier LSB is set, add the multiplicand to the upper 33 bits of the 64-bit accumulator, then shift right 1.
- RUN, divide: each edge, shift {rem,quot} left 1. If rem ≥ divisor, subtract and set the quotient LSB.
- RUN: counter decrements each edge; go to FIN when it reaches 0.
- FIN: apply sign correction, write hi/lo, assert done, return to IDLE.
- Signed multiply: 64-bit product is two's-complement negated if the operand signs differ.
- Signed divide:
  - quotient truncates toward zero
  - remainder takes the sign of the dividend
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0
- start while busy=1 is ignored; issue logic must not rely on it.
- x and y may change after the start cycle, since operands are latched.
- Reset (asynchronous, any state): state=IDLE, counter=0, hi=lo=0, busy=0, done=0, div_zero=0. An in-flight operation is discarded.

## Timing
- Start accepted at edge N. busy=1 from edge N through edge N+33.
- Multiply/divide: 32 iterations at edges N+1..N+32. FIN at edge N+33 updates hi/lo.
- During the cycle after edge N+33: done=1 and busy=0. Latency from start to result is 33 cycles.
- Divide by zero: FIN at edge N+1. done=1 and busy=0 in the cycle after edge N+1, with div_zero=1.
- mthi/mtlo: hi/lo visible the cycle after edge N; zero stall.
- A new start may be issued in the same cycle that done=1.
- hi/lo hold between operations. Intermediate accumulator values are never visible on hi/lo.

## Configuration
- MULDIV_SIGNED_EN defined:
  - ops 1 and 3 take magnitudes of two's-complement operands
  - ops 1 and 3 apply sign correction in FIN
- MULDIV_SIGNED_EN undefined:
  - ops 1 and 3 behave exactly as ops 0 and 2 (unsigned)
  - sign-correction logic is removed
  - timing is unchanged

## Test plan
- multu x=0xFFFFFFFF y=2 → done 33 cycles after start; hi=0x00000001, lo=0xFFFFFFFE.
- mult x=0xFFFFFFFF y=2 with MULDIV_SIGNED_EN → hi=0xFFFFFFFF, lo=0xFFFFFFFE. Without the macro, result is the same as multu.
- div x=0xFFFFFFF9 (−7) y=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 → lo=14, hi=2.
- divu x=7 y=0 with prior hi=0x11, lo=0x22 → done 1 cycle after start; div_zero=1; hi/lo unchanged. The next multu clears div_zero.
- mthi x=0xABCD then mtlo x=0x1234 on consecutive cycles → hi=0xABCD, lo=0x1234; busy never asserted. A start during busy leaves the running result unaffected.
- rst asserted at iteration 10 of a multu → busy, done and hi/lo go to 0 immediately. A following multu 3×5 gives lo=15, hi=0.
